// File: rtl/seq_div32.sv
// Iterative radix-2 restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands; default build is unsigned.
module seq_div32 #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             result_rdy,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    cnt_full = CW'(WIDTH);
  localparam logic [CW-1:0]    cnt_last = CW'(1);
  localparam logic [CW-1:0]    cnt_step = CW'(1);
  localparam logic [WIDTH-1:0] zero_w   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ones_w   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] one_w    = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] acc_r, q_r, dvs_r;
  logic [CW-1:0]    cnt_r;
  logic             qneg_r, rneg_r;
  logic             qneg_s, rneg_s, accept_s, dbz_s;
  logic [WIDTH-1:0] dnd_mag_s, dvs_mag_s, q_fix_s, r_fix_s;
  logic [WIDTH:0]   shift_s, trial_s;

  assign dbz_s    = (divisor == zero_w);
  assign accept_s = (state_r == IDLE) && start;

  // Operand magnitudes and result sign flags taken at accept.
  always_comb begin
    qneg_s    = 1'b0;
    rneg_s    = 1'b0;
    dnd_mag_s = dividend;
    dvs_mag_s = divisor;
`ifdef DIV_SIGNED_EN
    rneg_s = dividend[WIDTH-1];
    qneg_s = dividend[WIDTH-1] ^ divisor[WIDTH-1];
    if (dividend[WIDTH-1]) begin
      dnd_mag_s = (~dividend) + one_w;
    end else begin
      dnd_mag_s = dividend;
    end
    if (divisor[WIDTH-1]) begin
      dvs_mag_s = (~divisor) + one_w;
    end else begin
      dvs_mag_s = divisor;
    end
`endif
  end

  // Trial subtract is one bit wider than the partial remainder so the borrow lands in the MSB.
  always_comb begin
    shift_s = {acc_r, q_r[WIDTH-1]};
    trial_s = shift_s - {1'b0, dvs_r};
  end

  // Sign correction of the final magnitudes.
  always_comb begin
    q_fix_s = q_r;
    r_fix_s = acc_r;
    if (qneg_r) begin
      q_fix_s = (~q_r) + one_w;
    end else begin
      q_fix_s = q_r;
    end
    if (rneg_r) begin
      r_fix_s = (~acc_r) + one_w;
    end else begin
      r_fix_s = acc_r;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (dbz_s) begin
            state_s = DONE;
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == cnt_last) begin
          state_s = FIX;
        end else begin
          state_s = RUN;
        end
      end
      FIX:     state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath: operand capture and one restoring step per RUN cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_r  <= zero_w;
      q_r    <= zero_w;
      dvs_r  <= zero_w;
      cnt_r  <= {CW{1'b0}};
      qneg_r <= 1'b0;
      rneg_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start && !dbz_s) begin
            acc_r  <= zero_w;
            q_r    <= dnd_mag_s;
            dvs_r  <= dvs_mag_s;
            cnt_r  <= cnt_full;
            qneg_r <= qneg_s;
            rneg_r <= rneg_s;
          end
        end
        RUN: begin
          if (trial_s[WIDTH]) begin
            acc_r <= shift_s[WIDTH-1:0];
            q_r   <= {q_r[WIDTH-2:0], 1'b0};
          end else begin
            acc_r <= trial_s[WIDTH-1:0];
            q_r   <= {q_r[WIDTH-2:0], 1'b1};
          end
          cnt_r <= cnt_r - cnt_step;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Registered outputs; results only move when entering DONE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy        <= 1'b0;
      result_rdy  <= 1'b0;
      quotient    <= zero_w;
      remainder   <= zero_w;
      div_by_zero <= 1'b0;
    end else begin
      busy       <= (state_s != IDLE);
      result_rdy <= (state_r == DONE);
      if (accept_s && dbz_s) begin
        quotient    <= ones_w;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else if (state_r == FIX) begin
        quotient    <= q_fix_s;
        remainder   <= r_fix_s;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_div32.sv
// Directed bench for seq_div32: a latency/arithmetic model checked every cycle,
// plus literal expectations on each directed division.
module tb_seq_div32;
  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic        busy, result_rdy, div_by_zero;
  logic [31:0] quotient, remainder;

  int total = 0;
  int bad = 0;

  seq_div32 dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .result_rdy(result_rdy),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  // Reference division straight from the arithmetic rules.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic z);
    int sa, sb;
    z = (b == 32'd0);
    if (z) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
`ifdef DIV_SIGNED_EN
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        sa = a;
        sb = b;
        q = sa / sb;
        r = sa % sb;
      end
`else
      q = a / b;
      r = a % b;
`endif
    end
  endfunction

  // Model: cycles remaining until result_rdy; results appear one edge before it.
  int          m_left = 0;
  logic        m_busy = 1'b0, m_rdy = 1'b0, m_dbz = 1'b0;
  logic [31:0] m_q = 32'd0, m_r = 32'd0;
  logic [31:0] p_q, p_r;
  logic        p_z;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_left = 0; m_busy = 1'b0; m_rdy = 1'b0;
      m_q = 32'd0; m_r = 32'd0; m_dbz = 1'b0;
    end else begin
      m_rdy = 1'b0;
      if (m_left == 0) begin
        if (start) begin
          ref_div(dividend, divisor, p_q, p_r, p_z);
          m_left = p_z ? 1 : 34;
        end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) m_rdy = 1'b1;
      end
      if (m_left == 1) begin
        m_q = p_q; m_r = p_r; m_dbz = p_z;
      end
      m_busy = (m_left != 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    check("busy", {31'd0, busy}, {31'd0, m_busy});
    check("result_rdy", {31'd0, result_rdy}, {31'd0, m_rdy});
    check("quotient", quotient, m_q);
    check("remainder", remainder, m_r);
    check("div_by_zero", {31'd0, div_by_zero}, {31'd0, m_dbz});
  end

  task automatic wait_rdy(output int lat);
    lat = 0;
    while (!result_rdy && lat < 60) begin
      @(negedge clock);
      lat++;
    end
  endtask

  // Caller sits at a negedge; start is accepted at the following posedge.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er,
                        input logic ez, input int elat, input string name);
    int lat;
    dividend = a; divisor = b; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    dividend = 32'hDEAD_BEEF; divisor = 32'h0;
    wait_rdy(lat);
    check({name, " latency"}, lat, elat);
    check({name, " q"}, quotient, eq);
    check({name, " r"}, remainder, er);
    check({name, " dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
  endtask

  initial begin
    int lat;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("reset q", quotient, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    do_div(32'd100000, 32'd7, 32'd14285, 32'd5, 1'b0, 34, "t1");
    @(negedge clock);
    check("t1 busy after", {31'd0, busy}, 32'd0);

    do_div(32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1, "t2");
    @(negedge clock);
`ifdef DIV_SIGNED_EN
    do_div(32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34, "t3");
    @(negedge clock);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 34, "t4");
`else
    do_div(32'hFFFF_FF9C, 32'd7, 32'd613566742, 32'd2, 1'b0, 34, "t3");
    @(negedge clock);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 34, "t4");
`endif
    @(negedge clock);

    // Start pulse during RUN must be ignored.
    dividend = 32'd100; divisor = 32'd3; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_rdy(lat);
    check("t5 latency", lat, 24);
    check("t5 q", quotient, 32'd33);
    check("t5 r", remainder, 32'd1);
    @(negedge clock);

    // Asynchronous reset in the middle of RUN.
    dividend = 32'd100; divisor = 32'd3; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst rdy", {31'd0, result_rdy}, 32'd0);
    check("rst q", quotient, 32'd0);
    check("rst r", remainder, 32'd0);
    check("rst dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("rst idle", {31'd0, busy}, 32'd0);

    // Back-to-back: next start issued in the result_rdy cycle.
    do_div(32'd100000, 32'd7, 32'd14285, 32'd5, 1'b0, 34, "t6a");
`ifdef DIV_SIGNED_EN
    do_div(32'hFFFF_FFFF, 32'h10, 32'd0, 32'hFFFF_FFFF, 1'b0, 34, "t6b");
`else
    do_div(32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0, 34, "t6b");
`endif
    repeat (2) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
